// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default datapath width, the serial
// sequencer state encoding and the status-flag bundle that the status
// register consumes.
package arith_pkg;

    // Default operand/result width of the arithmetic datapath.
    localparam int N = 16;

    // Sequencer states of the bit-serial units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Status flags produced by a subtract (or compare) operation.
    typedef struct packed {
        logic borrow;
        logic zero;
        logic negative;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell, the subtract-side mirror of the
// full-adder cell: Diff = X - Y - Borrow_in, Borrow_out when that
// difference goes below zero.
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Borrow_in,
    output logic Diff,
    output logic Borrow_out
);

    assign Diff       = X ^ Y ^ Borrow_in;
    assign Borrow_out = (~X & Y) | (~X & Borrow_in) | (Y & Borrow_in);

endmodule

// File: rtl/serial_subtractor16.sv
// Bit-serial N-bit subtractor: computes A - B one bit per clock, LSB
// first, through a single full-subtractor cell with a registered borrow.
// Result and flags are reported through a start/done handshake and held
// until the next accepted start.
module serial_subtractor16
    import arith_pkg::*;
#(
    parameter int N = arith_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         borrow,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);

    localparam int CNT_W = $clog2(N);

    state_t           state_q;
    logic [N-1:0]     a_sh_q;
    logic [N-1:0]     b_sh_q;
    logic [N-1:0]     diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bin_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    flags_t           flags_q;

    logic             d_bit;
    logic             bout;
    logic             last_bit;
    logic             accept;
    logic [N-1:0]     diff_next;
    flags_t           flags_next;

    // The single arithmetic cell: current operand LSBs plus the stored borrow.
    full_subtractor u_cell (
        .X          (a_sh_q[0]),
        .Y          (b_sh_q[0]),
        .Borrow_in  (bin_q),
        .Diff       (d_bit),
        .Borrow_out (bout)
    );

    assign last_bit = (cnt_q == CNT_W'(N - 1));
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

    // Next Diff value and the flags it implies, used on the final RUN edge.
    // NOTE: every signal in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        diff_next           = {d_bit, diff_q[N-1:1]};
        flags_next          = '0;
        flags_next.borrow   = bout;
        flags_next.zero     = (diff_next == '0);
        flags_next.negative = diff_next[N-1];
        flags_next.overflow = (a_msb_q != b_msb_q) && (diff_next[N-1] != a_msb_q);
    end

    // Sequencer, operand shifters, borrow chain and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= RUN;
                        a_sh_q  <= A;
                        b_sh_q  <= B;
                        a_msb_q <= A[N-1];
                        b_msb_q <= B[N-1];
                        cnt_q   <= '0;
                        bin_q   <= 1'b0;
                        diff_q  <= '0;
                        flags_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    diff_q <= diff_next;
                    bin_q  <= bout;
                    a_sh_q <= {1'b0, a_sh_q[N-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[N-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q <= DONE;
                        flags_q <= flags_next;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Diff     = diff_q;
    assign borrow   = flags_q.borrow;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign overflow = flags_q.overflow;

endmodule
